lbp_hist: RTL and testbench
===========================

Name: lbp_hist

Overview:
- Stage directly downstream of the LBP engine.
- Consumes the LBP result stream (lbp_valid / lbp_addr / lbp_data / finish) for one 128x128 image.
- Accumulates a 256-bin histogram of LBP codes.
- After the engine signals finish, streams all 256 bin counts out over a valid/ready port, then raises done.

Parameters:
- IMG_W, 128, image width/height in pixels (power of two).
- AW, 14, pixel address width (log2(IMG_W*IMG_W)).
- CW, 14, bin counter width; counters saturate at 2^CW-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lbp_valid  in  1  one-cycle strobe; lbp_addr and lbp_data are valid this cycle.
- lbp_addr  in  AW  pixel address of the code; row = addr[AW-1:7], col = addr[6:0].
- lbp_data  in  8  LBP code (bin index).
- lbp_finish  in  1  level; LBP engine completed the image.
- hist_valid  out  1  bin count presented.
- hist_ready  in  1  consumer accepts the bin this cycle.
- hist_bin  out  8  bin index being presented.
- hist_count  out  CW  count for hist_bin.
- hist_done  out  1  all 256 bins accepted; sticky.
- px_count  out  AW  number of codes accumulated (saturating).
- border_err  out  1  sticky; a code arrived for a border pixel.

Behaviour:
- Reset is asynchronous, active-high, clock clk. On reset: all 256 bins = 0, state = ACCUM, hist_valid = 0, hist_bin = 0, hist_done = 0, px_count = 0, border_err = 0. hist_count shows bins[hist_bin], which is 0 after reset.
- Reset mid-operation (any state) discards all counts and restarts in ACCUM. A new image requires reset.

State ACCUM:
- Each cycle with lbp_valid = 1: bins[lbp_data] <= bins[lbp_data] + 1, saturating at 2^CW-1; px_count increments, saturating at 2^AW-1.
- Back-to-back valids, including the same code repeatedly, must each count. There is a single-cycle read-modify-write with no hazard.
- border_err is set if lbp_valid = 1 and any of: row = 0, row = IMG_W-1, col = 0, col = IMG_W-1. The code is still counted.
- lbp_finish = 1 -> DUMP on the next edge. A lbp_valid in the same cycle as lbp_finish is still counted.
- Entering DUMP: hist_valid <= 1, hist_bin <= 0.

State DUMP:
- hist_valid = 1. hist_count = bins[hist_bin], combinational read of the stable array; it is stable while hist_valid && !hist_ready.
- Transfer occurs when hist_valid && hist_ready. Then hist_bin increments.
- Transfer at hist_bin = 255 -> DONE, hist_valid <= 0, hist_done <= 1 (registered; visible the cycle after the final transfer).
- hist_ready may be held low indefinitely; outputs hold.
- lbp_valid is ignored in DUMP and DONE.

State DONE:
- Outputs frozen. hist_done = 1 until reset. lbp_valid and lbp_finish are ignored.

Latency:
- A count is visible in the array one cycle after its strobe.
- First bin is presented one cycle after lbp_finish is sampled high.
- Full dump takes 256 cycles minimum with hist_ready tied high.

Decomposition:
- Shared package lbp_pkg holds: IMG_W, AW, the LBP code width (8), NBINS = 256, and the state enumeration ACCUM/DUMP/DONE. The LBP engine uses the same package constants.
- One natural sub-module: lbp_border_chk, a combinational row/column border detect on an AW-bit address. It is reusable by the LBP engine for its skip logic.
- The histogram array stays inline.

Test Plan:
- Full 128x128 run, gray image constant 50 (all codes 255): 15876 valids -> bins[255] = 15876, all other bins 0, px_count = 15876, border_err = 0. Dump order is 0..255, then hist_done = 1.
- Back-to-back valids: 5 consecutive cycles with code 0x3C, then 1 cycle with 0x3D -> bins[0x3C] = 5, bins[0x3D] = 1.
- Valid coincident with lbp_finish (code 0x01) -> counted; bins[0x01] = 1; hist_valid rises next cycle with hist_bin = 0.
- Backpressure: hist_ready toggled 1-0-0-1 during dump -> each bin is transferred exactly once; hist_bin and hist_count hold while ready = 0; 256 transfers total.
- Saturation with CW = 4: 20 strobes of code 7 -> bins[7] = 15.
- Border address 0x0005 (row 0) with valid -> border_err = 1 next cycle and bin counted. Reset asserted mid-DUMP at bin 100 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/lbp_pkg.sv
// ============================================================================
// lbp_pkg : constants and state encoding shared by the LBP engine and histogram
// Revision: 1.0
// ============================================================================
`default_nettype none

package lbp_pkg;
    localparam int IMG_W  = 128;
    localparam int AW     = 14;
    localparam int RC_W   = $clog2(IMG_W);
    localparam int CODE_W = 8;
    localparam int NBINS  = 256;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/lbp_hist_if.sv
// ============================================================================
// lbp_hist_if : LBP code stream in, histogram bin stream and status out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lbp_hist_if
    import lbp_pkg::*;
#(
    parameter int CW = 14
);
    logic              lbp_valid;
    logic [AW-1:0]     lbp_addr;
    logic [CODE_W-1:0] lbp_data;
    logic              lbp_finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [CODE_W-1:0] hist_bin;
    logic [CW-1:0]     hist_count;
    logic              hist_done;
    logic [AW-1:0]     px_count;
    logic              border_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done, px_count, border_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done, px_count, border_err
    );
endinterface

`default_nettype wire

// File: rtl/lbp_border_chk.sv
// ============================================================================
// lbp_border_chk : flags pixel addresses on the outer row/column of the image
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbp_border_chk
    import lbp_pkg::*;
(
    input  wire logic [AW-1:0] addr,
    output logic               border
);
    logic [AW-RC_W-1:0] w_row;
    logic [RC_W-1:0]    w_col;

    assign w_row  = addr[AW-1:RC_W];
    assign w_col  = addr[RC_W-1:0];
    assign border = (w_row == '0) || (w_row == (AW-RC_W)'(IMG_W-1)) ||
                    (w_col == '0) || (w_col == RC_W'(IMG_W-1));
endmodule

`default_nettype wire

// File: rtl/lbp_hist.sv
// ============================================================================
// lbp_hist : accumulates a 256-bin LBP code histogram, then streams it out
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CW = 14
) (
    input  wire logic  clk,
    input  wire logic  reset,
    lbp_hist_if.slave  bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_bins [NBINS];
    logic [CODE_W-1:0] r_hist_bin;
    logic              r_hist_valid;
    logic              r_hist_done;
    logic              r_border_err;
    logic [AW-1:0]     r_px_count;
    logic              w_border;
    logic              w_accept;
    logic              w_enter;
    logic              w_xfer;
    logic              w_last;

    lbp_border_chk u_border (
        .addr   (bus.lbp_addr),
        .border (w_border)
    );

    assign w_last = (r_hist_bin == CODE_W'(NBINS-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ACCUM;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_enter     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ACCUM: begin
                w_accept = bus.lbp_valid;
                w_enter  = bus.lbp_finish;
                if (bus.lbp_finish) w_state_nxt = DUMP;
            end
            DUMP: begin
                w_xfer = r_hist_valid && bus.hist_ready;
                if (w_xfer && w_last) w_state_nxt = DONE;
            end
            default: ;
        endcase
    end

    // Single-cycle read-modify-write: each strobe sees the previous strobe's result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
        end else if (w_accept && (r_bins[bus.lbp_data] != '1)) begin
            r_bins[bus.lbp_data] <= r_bins[bus.lbp_data] + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px_count   <= '0;
            r_border_err <= 1'b0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_px_count != '1) r_px_count <= r_px_count + AW'(1);
                if (w_border)         r_border_err <= 1'b1;
            end
            if (w_enter) begin
                r_hist_valid <= 1'b1;
                r_hist_bin   <= '0;
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_hist_valid <= 1'b0;
                    r_hist_done  <= 1'b1;
                end else begin
                    r_hist_bin <= r_hist_bin + CODE_W'(1);
                end
            end
        end
    end

    assign bus.hist_valid = r_hist_valid;
    assign bus.hist_bin   = r_hist_bin;
    assign bus.hist_count = r_bins[r_hist_bin];
    assign bus.hist_done  = r_hist_done;
    assign bus.px_count   = r_px_count;
    assign bus.border_err = r_border_err;
endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
// ============================================================================
// tb_lbp_hist : directed, table-driven bench for lbp_hist (CW=14 and CW=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lbp_hist;
    import lbp_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   exp_bins [NBINS];

    typedef struct {
        logic [7:0]  code;
        logic [13:0] addr;
        logic        fin;
        int          exp_px;
        logic        exp_berr;
        logic        exp_hv;
    } vec_t;

    vec_t        vecs [8];
    logic [13:0] baddr [5];
    logic        bexp  [5];

    lbp_hist_if #(.CW(14)) ifa ();
    lbp_hist_if #(.CW(4))  ifs ();

    lbp_hist #(.CW(14)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    lbp_hist #(.CW(4))  u_dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NBINS; i++) exp_bins[i] = 0;
    endtask

    // Drains the main DUT; bp=1 applies a repeating 1-0-0-1 ready pattern
    task automatic dump_a(input bit bp);
        int          idx = 0;
        int          ph  = 0;
        logic        rdy;
        logic        stalled = 1'b0;
        logic [31:0] held_bin = 0;
        logic [31:0] held_cnt = 0;
        for (int cyc = 0; cyc < 2000 && idx < NBINS; cyc++) begin
            rdy = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ifa.hist_ready = rdy;
            if (stalled) begin
                chk("hold_bin", ifa.hist_bin, held_bin);
                chk("hold_cnt", ifa.hist_count, held_cnt);
            end
            if (ifa.hist_valid && rdy) begin
                chk("bin_idx", ifa.hist_bin, idx);
                chk("bin_cnt", ifa.hist_count, exp_bins[idx]);
                idx++;
            end
            stalled  = ifa.hist_valid && !rdy;
            held_bin = ifa.hist_bin;
            held_cnt = ifa.hist_count;
            step();
            ph++;
        end
        ifa.hist_ready = 1'b0;
        chk("xfers", idx, NBINS);
        chk("done_after_dump", ifa.hist_done, 1);
        chk("valid_after_dump", ifa.hist_valid, 0);
    endtask

    task automatic dump_s();
        int idx = 0;
        ifs.hist_ready = 1'b1;
        for (int cyc = 0; cyc < 600 && idx < NBINS; cyc++) begin
            if (ifs.hist_valid) begin
                chk("sat_bin_idx", ifs.hist_bin, idx);
                chk("sat_bin_cnt", ifs.hist_count, exp_bins[idx]);
                idx++;
            end
            step();
        end
        ifs.hist_ready = 1'b0;
        chk("sat_xfers", idx, NBINS);
        chk("sat_done", ifs.hist_done, 1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        ifa.lbp_valid = 0; ifa.lbp_addr = '0; ifa.lbp_data = '0; ifa.lbp_finish = 0; ifa.hist_ready = 0;
        ifs.lbp_valid = 0; ifs.lbp_addr = '0; ifs.lbp_data = '0; ifs.lbp_finish = 0; ifs.hist_ready = 0;

        vecs[0] = '{8'h3C, 14'h0081, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 14'h0081, 1'b0, 2, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 14'h0102, 1'b0, 3, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 14'h0103, 1'b0, 4, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 14'h0104, 1'b0, 5, 1'b0, 1'b0};
        vecs[5] = '{8'h3D, 14'h0105, 1'b0, 6, 1'b0, 1'b0};
        vecs[6] = '{8'h10, 14'h0005, 1'b0, 7, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 14'h0082, 1'b1, 8, 1'b1, 1'b1};

        baddr[0] = 14'h0080; bexp[0] = 1'b1;
        baddr[1] = 14'h00FF; bexp[1] = 1'b1;
        baddr[2] = 14'h3F81; bexp[2] = 1'b1;
        baddr[3] = 14'h3FFE; bexp[3] = 1'b1;
        baddr[4] = 14'h3F7E; bexp[4] = 1'b0;

        reset = 1'b1;
        step();
        chk("rst_hist_valid", ifa.hist_valid, 0);
        chk("rst_hist_bin",   ifa.hist_bin, 0);
        chk("rst_hist_count", ifa.hist_count, 0);
        chk("rst_hist_done",  ifa.hist_done, 0);
        chk("rst_px_count",   ifa.px_count, 0);
        chk("rst_border_err", ifa.border_err, 0);
        reset = 1'b0;
        step();

        // Full image of constant gray: every interior pixel yields code 255
        for (int r = 1; r < IMG_W - 1; r++) begin
            for (int c = 1; c < IMG_W - 1; c++) begin
                ifa.lbp_valid = 1'b1;
                ifa.lbp_addr  = 14'((r << 7) | c);
                ifa.lbp_data  = 8'hFF;
                step();
            end
        end
        ifa.lbp_valid  = 1'b0;
        ifa.lbp_finish = 1'b1;
        step();
        ifa.lbp_finish = 1'b0;
        chk("full_px_count", ifa.px_count, 15876);
        chk("full_border",   ifa.border_err, 0);
        chk("full_hv_rise",  ifa.hist_valid, 1);
        chk("full_first_bin", ifa.hist_bin, 0);
        clear_exp();
        exp_bins[255] = 15876;
        dump_a(1'b0);

        ifa.lbp_valid = 1'b1; ifa.lbp_data = 8'h03; ifa.lbp_addr = 14'h0005; ifa.lbp_finish = 1'b1;
        step();
        ifa.lbp_valid = 1'b0; ifa.lbp_finish = 1'b0;
        step();
        chk("done_px_frozen", ifa.px_count, 15876);
        chk("done_berr_frozen", ifa.border_err, 0);
        chk("done_sticky", ifa.hist_done, 1);
        chk("done_hv_low", ifa.hist_valid, 0);

        // Back-to-back codes, border strobe, valid coincident with finish
        do_reset();
        clear_exp();
        for (int i = 0; i < 8; i++) begin
            ifa.lbp_valid  = 1'b1;
            ifa.lbp_addr   = vecs[i].addr;
            ifa.lbp_data   = vecs[i].code;
            ifa.lbp_finish = vecs[i].fin;
            exp_bins[vecs[i].code]++;
            step();
            chk("vec_px_count", ifa.px_count, vecs[i].exp_px);
            chk("vec_border",   ifa.border_err, vecs[i].exp_berr);
            chk("vec_hv",       ifa.hist_valid, vecs[i].exp_hv);
        end
        ifa.lbp_valid  = 1'b0;
        ifa.lbp_finish = 1'b0;
        chk("vec_first_bin", ifa.hist_bin, 0);
        dump_a(1'b1);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            ifa.lbp_valid = 1'b1;
            ifa.lbp_addr  = baddr[i];
            ifa.lbp_data  = 8'h22;
            step();
            ifa.lbp_valid = 1'b0;
            chk("border_addr", ifa.border_err, bexp[i]);
            chk("border_px",   ifa.px_count, 1);
        end

        // Reset asserted between edges while bin 100 is presented
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ifa.lbp_valid = 1'b1; ifa.lbp_addr = 14'h0081; ifa.lbp_data = 8'h20;
            step();
        end
        ifa.lbp_valid  = 1'b0;
        ifa.lbp_finish = 1'b1;
        step();
        ifa.lbp_finish = 1'b0;
        ifa.hist_ready = 1'b1;
        for (int k = 0; k < 300 && ifa.hist_bin != 8'd100; k++) step();
        chk("reach_bin100", ifa.hist_bin, 100);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hv",     ifa.hist_valid, 0);
        chk("mid_rst_bin",    ifa.hist_bin, 0);
        chk("mid_rst_count",  ifa.hist_count, 0);
        chk("mid_rst_done",   ifa.hist_done, 0);
        chk("mid_rst_px",     ifa.px_count, 0);
        chk("mid_rst_berr",   ifa.border_err, 0);
        ifa.hist_ready = 1'b0;
        step();
        reset = 1'b0;
        ifa.lbp_finish = 1'b1;
        step();
        ifa.lbp_finish = 1'b0;
        clear_exp();
        dump_a(1'b0);

        // Saturation on the narrow-counter instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ifs.lbp_valid = 1'b1; ifs.lbp_addr = 14'h0081; ifs.lbp_data = 8'h07;
            step();
        end
        ifs.lbp_valid  = 1'b0;
        ifs.lbp_finish = 1'b1;
        step();
        ifs.lbp_finish = 1'b0;
        chk("sat_px_count", ifs.px_count, 20);
        clear_exp();
        exp_bins[7] = 15;
        dump_s();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
